cart_rom_mapper: RTL and testbench
==================================

Name: cart_rom_mapper

Overview:
- Consumer side of the ROM download/detection path: takes the detected mapper code, start offset and ROM size, and serves Z80 cartridge-slot accesses.
- Holds bank registers updated by CPU writes and translates 16-bit CPU addresses into 25-bit ROM (SDRAM) addresses.
- Also produces Game Master 2 SRAM selects and the Konami SCC window select.
- Sits between the slot decoder and the ROM/SRAM memory arbiter.

Parameters:
- SRAM_AW, 13, Game Master 2 SRAM address width (8 KB).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mapper  in  3  0 unknown, 1 plain, 2 gamemaster2, 3 konami, 4 konami SCC, 5 ASCII8, 6 ASCII16
- offset  in  4  plain-ROM base in 4 KB units (0, 4 or 8)
- rom_size  in  25  loaded image size in bytes
- cs  in  1  cartridge slot selected
- cpu_addr  in  16  Z80 address
- cpu_din  in  8  Z80 write data
- cpu_wr  in  1  one-cycle write strobe
- cpu_rd  in  1  one-cycle read strobe
- mem_addr  out  25  ROM byte address
- mem_rd  out  1  ROM read request
- sram_addr  out  SRAM_AW  SRAM byte address
- sram_rd  out  1  SRAM read request
- sram_we  out  1  SRAM write request
- scc_sel  out  1  access hits the SCC register window
- unmapped  out  1  read outside the image; the data mux returns FF

Behaviour:
- Reset:
  - All outputs are 0.
  - Bank registers: konami/SCC/GM2 banks = 0,1,2,3; ASCII8 = 0,0,0,0; ASCII16 = 0,0.
  - rom_mask = 0.
- Mapper change: the mapper input is registered. Any change loads the bank defaults for the new mapper on the next cycle, exactly as reset does.
- rom_mask is recomputed every cycle as next power of two ≥ rom_size, minus 1. It is registered, so it has 1-cycle latency.
- Accesses are decoded only when cs=1. cpu_wr and cpu_rd are never asserted together.
- Outputs are registered: a strobe in cycle N gives outputs in cycle N+1, held for one cycle only.
- A bank write in cycle N affects reads issued in cycle N+1 and later.
- Bank windows are 8 KB (page p = cpu_addr[15:13], banks at pages 2..5); mem_addr = {bank, cpu_addr[12:0]} & rom_mask. ASCII16 uses 16 KB banks: {bank, cpu_addr[13:0]}.
- Address windows outside 4000-BFFF: unmapped=1, no mem_rd.
- Plain (0/1): mem_addr = (cpu_addr - offset*4096) & rom_mask. If the unmasked result is ≥ rom_size or the subtraction underflows, unmapped=1. Writes are ignored.
- Konami (3):
  - Bank 0 is fixed at 0.
  - Writes to 6000-7FFF, 8000-9FFF and A000-BFFF set banks 1, 2 and 3.
  - Writes to 4000-5FFF are ignored.
- Konami SCC (4):
  - Writes to 5000-57FF, 7000-77FF, 9000-97FF and B000-B7FF set banks 0..3.
  - When bank2[5:0]==3F, accesses to 9800-9FFF assert scc_sel instead of mem_rd. Bank writes still apply.
- ASCII8 (5): writes to 6000-67FF, 6800-6FFF, 7000-77FF and 7800-7FFF set banks 0..3 (windows 4000/6000/8000/A000).
- ASCII16 (6): writes to 6000-67FF and 7000-77FF set bank 0 (4000-7FFF) and bank 1 (8000-BFFF).
- Game Master 2 (2):
  - Bank 0 is fixed at 0. Writes to 6000-6FFF, 8000-8FFF and A000-AFFF set banks 1..3.
  - If bank[4]=1 the window maps SRAM: sram_addr = {bank[5], cpu_addr[11:0]}, and the read gives sram_rd.
  - sram_we only for a cpu_wr at B000-BFFF while bank3[4]=1. In that case no bank update happens.
- Bank registers are 8 bits; values beyond the image size wrap via rom_mask.
- Writes never assert mem_rd; ROM is never written.
- reset has priority over any strobe in the same cycle.

Decomposition:
- Shared package cart_pkg holds:
  - mapper code constants MAP_NONE..MAP_ASCII16;
  - default bank tables;
  - window base constants.
- Sub-module cart_bank_regs: the bank register file with per-mapper write decode and default loading. The top level does translation and output registering.

Test Plan:
- Plain, mapper=1, offset=4, rom_size=8000: read 4123 -> mem_addr 000123; read C000 -> unmapped=1.
- Konami: write 8000<=05, then read 8010 in the next cycle -> mem_addr 0A010; reset -> the same read gives 04010.
- SCC, rom_size=40000: write 9000<=3F, read 9880 -> scc_sel=1, mem_rd=0; write 9000<=02, read 9880 -> mem_addr 05880.
- ASCII16, rom_size=20000: write 7000<=0B -> read 8001 gives mem_addr 0C001 (bank masked 0B&7=3).
- GM2: write A000<=30, write B005<=AA -> sram_we=1, sram_addr 1005; read A005 -> sram_rd=1, sram_addr 1005.
- Switch mapper 5->3 mid-run after ASCII8 writes -> banks become 0,1,2,3 one cycle later; reset asserted with cpu_wr -> no bank update.

Source files
------------

// File: rtl/cart_pkg.sv
// Shared mapper codes, bank defaults and address-window constants for the
// cartridge ROM mapper.
package cart_pkg;

    localparam logic [2:0] MAP_NONE    = 3'd0;
    localparam logic [2:0] MAP_PLAIN   = 3'd1;
    localparam logic [2:0] MAP_GM2     = 3'd2;
    localparam logic [2:0] MAP_KONAMI  = 3'd3;
    localparam logic [2:0] MAP_SCC     = 3'd4;
    localparam logic [2:0] MAP_ASCII8  = 3'd5;
    localparam logic [2:0] MAP_ASCII16 = 3'd6;

    localparam int unsigned NUM_BANKS = 4;

    typedef logic [NUM_BANKS-1:0][7:0] bank_file_t;

    localparam bank_file_t BANKS_LINEAR = {8'd3, 8'd2, 8'd1, 8'd0};
    localparam bank_file_t BANKS_ZERO   = '0;

    // 8 KB pages 2..5 cover the 4000-BFFF cartridge window.
    localparam logic [2:0] PAGE_FIRST     = 3'd2;
    localparam logic [2:0] PAGE_LAST      = 3'd5;
    localparam logic [2:0] PAGE_REG_FIRST = 3'd3;        // 6000: first writable bank page
    localparam logic [2:0] ASCII_REG_PAGE = 3'd3;        // 6000-7FFF
    localparam logic [4:0] SCC_REG_SLOT   = 5'b10011;    // 9800-9FFF
    localparam logic [3:0] GM2_SRAM_SLOT  = 4'hB;        // B000-BFFF

    function automatic bank_file_t default_banks(input logic [2:0] map);
        return (map == MAP_ASCII8 || map == MAP_ASCII16) ? BANKS_ZERO : BANKS_LINEAR;
    endfunction

    // Next power of two >= size, minus one.
    function automatic logic [24:0] size_to_mask(input logic [24:0] size);
        logic [24:0] m;
        m = size - 25'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        m = m | (m >> 16);
        return (size <= 25'd1) ? '0 : m;
    endfunction

endpackage

// File: rtl/cart_bank_regs.sv
// Bank register file: registers the mapper code, decodes per-mapper bank
// writes and reloads defaults on reset or on any mapper change.
module cart_bank_regs
    import cart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  mapper,
    input  logic        cs,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_wr,
    output logic [2:0]  mapper_q,
    output bank_file_t  banks_q
);

    logic [2:0] page;
    logic       wr_hit;
    logic [1:0] wr_idx;
    bank_file_t banks_d;

    assign page = cpu_addr[15:13];

    always_comb begin
        wr_hit = 1'b0;
        wr_idx = 2'(page - PAGE_FIRST);
        unique case (mapper_q)
            MAP_KONAMI: wr_hit = page inside {[PAGE_REG_FIRST:PAGE_LAST]};
            MAP_SCC: begin
                // x000-x7FF at the top half of each 8 KB page
                wr_hit = (page inside {[PAGE_FIRST:PAGE_LAST]}) && (cpu_addr[12:11] == 2'b10);
            end
            MAP_ASCII8: begin
                wr_hit = (page == ASCII_REG_PAGE);
                wr_idx = cpu_addr[12:11];
            end
            MAP_ASCII16: begin
                wr_hit = (page == ASCII_REG_PAGE) && !cpu_addr[11];
                wr_idx = {1'b0, cpu_addr[12]};
            end
            MAP_GM2: begin
                wr_hit = (page inside {[PAGE_REG_FIRST:PAGE_LAST]}) && !cpu_addr[12];
            end
            default: ;
        endcase
    end

    always_comb begin
        banks_d = banks_q;
        if (cs && cpu_wr && wr_hit) begin
            banks_d[wr_idx] = cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (mapper != mapper_q)) begin
            mapper_q <= mapper;
            banks_q  <= default_banks(mapper);
        end else begin
            banks_q  <= banks_d;
        end
    end

endmodule

// File: rtl/cart_rom_mapper.sv
// Cartridge-slot mapper: translates Z80 accesses into ROM/SRAM requests using
// the bank registers, with one cycle of output registering.
module cart_rom_mapper
    import cart_pkg::*;
#(
    parameter int unsigned SRAM_AW = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         mapper,
    input  logic [3:0]         offset,
    input  logic [24:0]        rom_size,
    input  logic               cs,
    input  logic [15:0]        cpu_addr,
    input  logic [7:0]         cpu_din,
    input  logic               cpu_wr,
    input  logic               cpu_rd,
    output logic [24:0]        mem_addr,
    output logic               mem_rd,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_rd,
    output logic               sram_we,
    output logic               scc_sel,
    output logic               unmapped
);

    logic [2:0]  mapper_q;
    bank_file_t  banks_q;
    logic [24:0] rom_mask_q;

    cart_bank_regs u_bank_regs (
        .clk      (clk),
        .reset    (reset),
        .mapper   (mapper),
        .cs       (cs),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_wr   (cpu_wr),
        .mapper_q (mapper_q),
        .banks_q  (banks_q)
    );

    logic [2:0]  page;
    logic        in_window;
    logic        scc_hit;
    logic [7:0]  bank8k;
    logic [7:0]  bank16k;
    logic [24:0] addr8k;
    logic [24:0] addr16k;
    logic [16:0] plain_diff;

    assign page       = cpu_addr[15:13];
    assign in_window  = page inside {[PAGE_FIRST:PAGE_LAST]};
    assign bank8k     = banks_q[2'(page - PAGE_FIRST)];
    assign bank16k    = banks_q[{1'b0, cpu_addr[15]}];
    assign addr8k     = 25'({bank8k, cpu_addr[12:0]}) & rom_mask_q;
    assign addr16k    = 25'({bank16k, cpu_addr[13:0]}) & rom_mask_q;
    // Bit 16 flags an address below the plain-ROM base.
    assign plain_diff = {1'b0, cpu_addr} - {1'b0, offset, 12'h000};
    assign scc_hit    = (mapper_q == MAP_SCC) && (banks_q[2][5:0] == 6'h3F) &&
                        (cpu_addr[15:11] == SCC_REG_SLOT);

    logic [24:0]        mem_addr_d;
    logic               mem_rd_d;
    logic [SRAM_AW-1:0] sram_addr_d;
    logic               sram_rd_d;
    logic               sram_we_d;
    logic               scc_sel_d;
    logic               unmapped_d;

    always_comb begin
        mem_addr_d  = '0;
        mem_rd_d    = 1'b0;
        sram_addr_d = '0;
        sram_rd_d   = 1'b0;
        sram_we_d   = 1'b0;
        scc_sel_d   = 1'b0;
        unmapped_d  = 1'b0;
        if (cs && (cpu_rd || cpu_wr)) begin
            unique case (mapper_q)
                MAP_NONE, MAP_PLAIN: begin
                    if (cpu_rd) begin
                        if (plain_diff[16] || (25'(plain_diff[15:0]) >= rom_size)) begin
                            unmapped_d = 1'b1;
                        end else begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = 25'(plain_diff[15:0]) & rom_mask_q;
                        end
                    end
                end
                MAP_GM2: begin
                    if (cpu_wr) begin
                        if ((cpu_addr[15:12] == GM2_SRAM_SLOT) && banks_q[3][4]) begin
                            sram_we_d   = 1'b1;
                            sram_addr_d = SRAM_AW'({banks_q[3][5], cpu_addr[11:0]});
                        end
                    end else if (!in_window) begin
                        unmapped_d = 1'b1;
                    end else if (bank8k[4]) begin
                        sram_rd_d   = 1'b1;
                        sram_addr_d = SRAM_AW'({bank8k[5], cpu_addr[11:0]});
                    end else begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = addr8k;
                    end
                end
                MAP_ASCII16: begin
                    if (cpu_rd) begin
                        if (!in_window) begin
                            unmapped_d = 1'b1;
                        end else begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr16k;
                        end
                    end
                end
                default: begin
                    // Konami, Konami SCC and ASCII8 share 8 KB read translation.
                    if (scc_hit) begin
                        scc_sel_d = 1'b1;
                    end else if (cpu_rd) begin
                        if (!in_window) begin
                            unmapped_d = 1'b1;
                        end else begin
                            mem_rd_d   = 1'b1;
                            mem_addr_d = addr8k;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rom_mask_q <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            sram_addr  <= '0;
            sram_rd    <= 1'b0;
            sram_we    <= 1'b0;
            scc_sel    <= 1'b0;
            unmapped   <= 1'b0;
        end else begin
            rom_mask_q <= size_to_mask(rom_size);
            mem_addr   <= mem_addr_d;
            mem_rd     <= mem_rd_d;
            sram_addr  <= sram_addr_d;
            sram_rd    <= sram_rd_d;
            sram_we    <= sram_we_d;
            scc_sel    <= scc_sel_d;
            unmapped   <= unmapped_d;
        end
    end

endmodule

// File: tb/tb_cart_rom_mapper.sv
// Randomized bench for cart_rom_mapper against an address-range reference
// model, preceded by directed scenarios with fixed expected values.
module tb_cart_rom_mapper;

    localparam int unsigned SRAM_AW = 13;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [2:0]         mapper = 3'd1;
    logic [3:0]         offset = 4'd0;
    logic [24:0]        rom_size = 25'h8000;
    logic               cs = 1'b0;
    logic [15:0]        cpu_addr = '0;
    logic [7:0]         cpu_din = '0;
    logic               cpu_wr = 1'b0;
    logic               cpu_rd = 1'b0;
    logic [24:0]        mem_addr;
    logic               mem_rd;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_rd;
    logic               sram_we;
    logic               scc_sel;
    logic               unmapped;

    cart_rom_mapper #(.SRAM_AW(SRAM_AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mapper    (mapper),
        .offset    (offset),
        .rom_size  (rom_size),
        .cs        (cs),
        .cpu_addr  (cpu_addr),
        .cpu_din   (cpu_din),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .sram_addr (sram_addr),
        .sram_rd   (sram_rd),
        .sram_we   (sram_we),
        .scc_sel   (scc_sel),
        .unmapped  (unmapped)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    int unsigned cur_map = 1;
    int unsigned m_map = 0;
    int unsigned m_bank[4];
    int unsigned m_mask = 0;

    int unsigned e_addr, e_sram_addr;
    bit          e_rd, e_srd, e_swe, e_scc, e_unm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ref_mask(input int unsigned size);
        int unsigned p = 1;
        while (p < size) p = p * 2;
        return p - 1;
    endfunction

    function automatic bit bit_of(input int unsigned v, input int unsigned n);
        return ((v >> n) % 2) == 1;
    endfunction

    // Computes this cycle's expected outputs, then advances model state.
    task automatic model_cycle(input bit r, input int unsigned m, input bit c,
                               input int unsigned a, input int unsigned d,
                               input bit w, input bit rd);
        int unsigned b, base;
        bit inwin;
        e_addr = 0; e_sram_addr = 0;
        e_rd = 0; e_srd = 0; e_swe = 0; e_scc = 0; e_unm = 0;
        inwin = (a >= 'h4000) && (a < 'hC000);
        if (!r && c && (w || rd)) begin
            case (m_map)
                0, 1: if (rd) begin
                    base = offset * 4096;
                    if (a < base || (a - base) >= rom_size) e_unm = 1;
                    else begin
                        e_rd = 1;
                        e_addr = (a - base) & m_mask;
                    end
                end
                2: begin
                    if (w) begin
                        if (a >= 'hB000 && a < 'hC000 && bit_of(m_bank[3], 4)) begin
                            e_swe = 1;
                            e_sram_addr = (bit_of(m_bank[3], 5) ? 4096 : 0) + a % 4096;
                        end
                    end else if (!inwin) e_unm = 1;
                    else begin
                        b = m_bank[(a - 'h4000) / 'h2000];
                        if (bit_of(b, 4)) begin
                            e_srd = 1;
                            e_sram_addr = (bit_of(b, 5) ? 4096 : 0) + a % 4096;
                        end else begin
                            e_rd = 1;
                            e_addr = (b * 8192 + a % 8192) & m_mask;
                        end
                    end
                end
                6: if (rd) begin
                    if (!inwin) e_unm = 1;
                    else begin
                        e_rd = 1;
                        e_addr = (m_bank[(a - 'h4000) / 'h4000] * 16384 + a % 16384) & m_mask;
                    end
                end
                default: begin
                    if (m_map == 4 && (m_bank[2] % 64) == 63 && a >= 'h9800 && a < 'hA000)
                        e_scc = 1;
                    else if (rd) begin
                        if (!inwin) e_unm = 1;
                        else begin
                            e_rd = 1;
                            e_addr = (m_bank[(a - 'h4000) / 'h2000] * 8192 + a % 8192) & m_mask;
                        end
                    end
                end
            endcase
        end
        if (r || m != m_map) begin
            m_map = m;
            for (int i = 0; i < 4; i++) m_bank[i] = (m == 5 || m == 6) ? 0 : i;
        end else if (c && w) begin
            case (m_map)
                3: if (a >= 'h6000 && a < 'hC000) m_bank[(a - 'h4000) / 'h2000] = d;
                4: for (int i = 0; i < 4; i++)
                       if (a >= 'h5000 + i * 'h2000 && a < 'h5800 + i * 'h2000) m_bank[i] = d;
                5: for (int i = 0; i < 4; i++)
                       if (a >= 'h6000 + i * 'h800 && a < 'h6800 + i * 'h800) m_bank[i] = d;
                6: begin
                    if (a >= 'h6000 && a < 'h6800) m_bank[0] = d;
                    if (a >= 'h7000 && a < 'h7800) m_bank[1] = d;
                end
                2: for (int i = 1; i < 4; i++)
                       if (a >= 'h4000 + i * 'h2000 && a < 'h5000 + i * 'h2000) m_bank[i] = d;
                default: ;
            endcase
        end
        m_mask = r ? 0 : ref_mask(rom_size);
    endtask

    task automatic step(input bit r, input bit c, input int unsigned a, input int unsigned d,
                        input bit w, input bit rd);
        @(negedge clk);
        reset    = r;
        mapper   = 3'(cur_map);
        cs       = c;
        cpu_addr = 16'(a);
        cpu_din  = 8'(d);
        cpu_wr   = w;
        cpu_rd   = rd;
        model_cycle(r, cur_map, c, a, d, w, rd);
        @(posedge clk);
        #1;
        check("mem_addr", 32'(mem_addr), e_addr);
        check("mem_rd", 32'(mem_rd), 32'(e_rd));
        check("sram_addr", 32'(sram_addr), e_sram_addr);
        check("sram_rd", 32'(sram_rd), 32'(e_srd));
        check("sram_we", 32'(sram_we), 32'(e_swe));
        check("scc_sel", 32'(scc_sel), 32'(e_scc));
        check("unmapped", 32'(unmapped), 32'(e_unm));
    endtask

    task automatic rd_at(input int unsigned a);
        step(0, 1, a, 0, 0, 1);
    endtask

    task automatic wr_at(input int unsigned a, input int unsigned d);
        step(0, 1, a, d, 1, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Plain ROM at 4000, 32 KB
        cur_map = 1; offset = 4; rom_size = 25'h8000;
        step(1, 0, 0, 0, 0, 0);
        check("reset_mem_rd", 32'(mem_rd), 0);
        check("reset_unmapped", 32'(unmapped), 0);
        idle();
        rd_at('h4123);
        check("plain_addr", 32'(mem_addr), 'h123);
        rd_at('hC000);
        check("plain_unmapped", 32'(unmapped), 1);

        // Konami bank write then reset
        cur_map = 3; rom_size = 25'h20000;
        idle();
        wr_at('h8000, 'h05);
        rd_at('h8010);
        check("konami_bank", 32'(mem_addr), 'hA010);
        step(1, 0, 0, 0, 0, 0);
        idle();
        rd_at('h8010);
        check("konami_after_reset", 32'(mem_addr), 'h4010);

        // Konami SCC register window
        cur_map = 4; rom_size = 25'h40000;
        idle();
        wr_at('h9000, 'h3F);
        rd_at('h9880);
        check("scc_sel_on", 32'(scc_sel), 1);
        check("scc_no_mem_rd", 32'(mem_rd), 0);
        wr_at('h9000, 'h02);
        rd_at('h9880);
        check("scc_rom_addr", 32'(mem_addr), 'h5880);

        // ASCII16 with bank masked by image size
        cur_map = 6; rom_size = 25'h20000;
        idle();
        wr_at('h7000, 'h0B);
        rd_at('h8001);
        check("ascii16_masked", 32'(mem_addr), 'hC001);

        // Game Master 2 SRAM
        cur_map = 2;
        idle();
        wr_at('hA000, 'h30);
        wr_at('hB005, 'hAA);
        check("gm2_sram_we", 32'(sram_we), 1);
        check("gm2_we_addr", 32'(sram_addr), 'h1005);
        rd_at('hA005);
        check("gm2_sram_rd", 32'(sram_rd), 1);
        check("gm2_rd_addr", 32'(sram_addr), 'h1005);

        // ASCII8 writes, then mapper switch to Konami
        cur_map = 5; rom_size = 25'h200000;
        idle();
        wr_at('h6000, 'h11);
        wr_at('h6800, 'h22);
        wr_at('h7000, 'h33);
        wr_at('h7800, 'h44);
        rd_at('h4000);
        check("ascii8_bank0", 32'(mem_addr), 'h22000);
        cur_map = 3;
        rd_at('hA000);
        check("switch_same_cycle", 32'(mem_addr), 'h88000);
        rd_at('h4000);
        check("switch_bank0", 32'(mem_addr), 'h0000);
        rd_at('h6000);
        check("switch_bank1", 32'(mem_addr), 'h2000);
        rd_at('hA000);
        check("switch_bank3", 32'(mem_addr), 'h6000);

        // Reset wins over a simultaneous bank write
        step(1, 1, 'h8000, 'h07, 1, 0);
        idle();
        rd_at('h8000);
        check("reset_blocks_write", 32'(mem_addr), 'h4000);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned sel, a, d;
            sel = $urandom_range(0, 99);
            a   = $urandom_range(0, 65535);
            d   = ($urandom_range(0, 3) == 0) ? 'h3F : $urandom_range(0, 255);
            if (sel < 2) begin
                step(1, 1, a, d, 1, 0);
            end else if (sel < 6) begin
                cur_map = $urandom_range(0, 6);
                rd_at(a);
            end else if (sel < 9) begin
                offset   = 4'($urandom_range(0, 2) * 4);
                rom_size = ($urandom_range(0, 1) == 0) ? 25'($urandom_range(1, 'h10000))
                                                       : 25'($urandom_range(1, 'h200000));
                idle();
            end else if (sel < 45) begin
                wr_at(a, d);
            end else if (sel < 92) begin
                rd_at(a);
            end else begin
                step(0, 0, a, d, $urandom_range(0, 1), 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
